alu_serial: RTL

Digit-serial integer ALU executing the 3-bit ALU control codes produced by the ALU decoder (ADD, SUB, OR, AND, SLT) over WIDTH/DIGIT clock cycles. It sits between the register file and the writeback mux in the area-reduced core variant. Operands and control are accepted with a valid/ready handshake, and the result plus zero flag are returned with a second valid/ready handshake.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_digit.sv | 40 ++++
 rtl/alu_serial.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and FSM state encoding shared by the decoder
// and the digit-serial ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // SUB and SLT both compute a + ~b + 1.
  function automatic logic op_is_sub(input logic [2:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_digit.sv
// alu_digit: combinational DIGIT-bit ALU slice, time-multiplexed by the
// serial ALU. Code 100 is XOR only when ALU_XOR_EN is defined; otherwise it
// and all other unsupported codes produce zero.
module alu_digit
  import alu_pkg::*;
#(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             carry_in,
  input  logic [2:0]       op,
  output logic [DIGIT-1:0] res,
  output logic             carry_out
);

  logic [DIGIT-1:0] b_eff;
  logic [DIGIT:0]   sum_ext;

  // Adder with optional B inversion, then per-op result select.
  always_comb begin
    b_eff     = op_is_sub(op) ? ~b : b;
    sum_ext   = {1'b0, a} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry_in};
    res       = '0;
    carry_out = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB, ALU_SLT: begin
        res       = sum_ext[DIGIT-1:0];
        carry_out = sum_ext[DIGIT];
      end
      ALU_OR:  res = a | b;
      ALU_AND: res = a & b;
`ifdef ALU_XOR_EN
      ALU_XOR: res = a ^ b;
`endif
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU (ADD/SUB/OR/AND/SLT, optional XOR when
// ALU_XOR_EN is defined). Processes DIGIT bits per cycle, LSB first.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and in_valid/operands are only
// sampled at the accepting edge.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output alu_state_e       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, zero_q, zero_d;

  logic             accept, last_digit, slt_lt, ovf;
  logic [DIGIT-1:0] dig_res;
  logic             dig_cout;
  logic [WIDTH-1:0] shifted;

  alu_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (a_q[DIGIT-1:0]),
    .b        (b_q[DIGIT-1:0]),
    .carry_in (carry_q),
    .op       (op_q),
    .res      (dig_res),
    .carry_out(dig_cout)
  );

  assign last_digit = (cnt_q == CW'(N - 1));
  assign accept     = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)     state_d = ST_RUN;
      ST_RUN:  if (last_digit) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs; accepts are blocked while reset is held.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && rst_n;
    out_valid = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  // Signed less-than from the top digit of a + ~b + 1.
  always_comb begin
    ovf    = (a_q[DIGIT-1] == ~b_q[DIGIT-1]) && (dig_res[DIGIT-1] != a_q[DIGIT-1]);
    slt_lt = dig_res[DIGIT-1] ^ ovf;
  end

  // Datapath next values: latch on accept, shift one digit per RUN cycle.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    zero_d   = zero_q;
    shifted  = {dig_res, result_q[WIDTH-1:DIGIT]};
    if (accept) begin
      a_d      = src_a;
      b_d      = src_b;
      op_d     = alu_control;
      cnt_d    = '0;
      carry_d  = op_is_sub(alu_control);
      result_d = '0;
      zero_d   = 1'b0;
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      carry_d = dig_cout;
      if (last_digit) begin
        cnt_d    = '0;
        result_d = (op_q == ALU_SLT) ? {{(WIDTH-1){1'b0}}, slt_lt} : shifted;
        zero_d   = (result_d == '0);
      end else begin
        cnt_d    = cnt_q + CW'(1);
        result_d = shifted;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule
